bcd_conv_arbiter: RTL and testbench



---
 rtl/bcd_ctrl_pkg.sv | 40 ++++
 rtl/BIN_to_BCD.sv | 41 ++++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/bcd_conv_arbiter.sv | 130 +++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_ctrl_pkg.sv
// Shared constants and helpers for the BCD converter arbiter.
package bcd_ctrl_pkg;

  localparam logic [3:0] BCD_SIGN_POS = 4'hC;
  localparam logic [3:0] BCD_SIGN_NEG = 4'hA;
  localparam logic [3:0] BCD_SIGN_OVF = 4'hB;

  // Widest requester set the round-robin helper supports.
  localparam int unsigned RR_MAX   = 8;
  localparam int unsigned RR_IDX_W = 3;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid at or after ptr, searched cyclically over n entries.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && !r.found && valid[j[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/BIN_to_BCD.sv
// Combinational binary-to-BCD converter (shift/add-3) with a sign nibble on top.
// Magnitudes above 10^(DIGITS-1)-1 keep only their low decimal digits.
module BIN_to_BCD
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter int unsigned DIGITS = 6
) (
  input  logic [BITS-1:0]     bin_i,
  input  logic                sign_i,
  input  logic                over_i,
  input  logic                com_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  localparam int unsigned MAG_W = 4 * (DIGITS - 1);

  logic [MAG_W-1:0] mag;
  logic [3:0]       sign_nib;

  // Double-dabble: correct each nibble before every shift of a new bit.
  always_comb begin
    mag = '0;
    for (int i = BITS - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS - 1; d++) begin
        if (mag[4*d +: 4] >= 4'd5) mag[4*d +: 4] = mag[4*d +: 4] + 4'd3;
      end
      mag = {mag[MAG_W-2:0], bin_i[i]};
    end
  end

  // Sign code priority: complemented overflow, then negative, else positive.
  always_comb begin
    sign_nib = BCD_SIGN_POS;
    if (com_i && over_i) sign_nib = BCD_SIGN_OVF;
    else if (sign_i)     sign_nib = BCD_SIGN_NEG;
  end

  assign bcd_o = {sign_nib, mag};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pointer and one-hot grant for the shared converter.
module rr_arbiter
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned REQS = 4,
  parameter int unsigned IDW  = id_width(REQS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REQS-1:0] valid_i,
  input  logic            en_i,
  output logic [REQS-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            found_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  rr_pick_t       pick;

  // Winner search and pointer advance past the granted index.
  always_comb begin
    pick    = rr_pick(RR_MAX'(valid_i), RR_IDX_W'(ptr_q), REQS);
    idx_o   = IDW'(pick.idx);
    found_o = pick.found;
    grant_o = '0;
    ptr_d   = ptr_q;
    if (pick.found && en_i) begin
      grant_o = REQS'(1) << idx_o;
      ptr_d   = (idx_o == IDW'(REQS - 1)) ? '0 : idx_o + IDW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one BIN_to_BCD among REQS requesters with round-robin arbitration and
// a back-pressurable registered result tagged with the requester index.
// Optional macro BCD_CONV_PIPE_EN adds a stage-1 register ahead of the converter.
module bcd_conv_arbiter
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter int unsigned DIGITS = 6,
  parameter int unsigned REQS   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQS-1:0]            req_valid,
  output logic [REQS-1:0]            req_ready,
  input  logic [REQS-1:0][BITS-1:0]  req_bin,
  input  logic [REQS-1:0]            req_sign,
  input  logic [REQS-1:0]            req_over,
  input  logic [REQS-1:0]            req_com,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*DIGITS-1:0]        out_bcd,
  output logic [id_width(REQS)-1:0]  out_id
);

  localparam int unsigned IDW   = id_width(REQS);
  localparam int unsigned BCD_W = 4 * DIGITS;

  logic [REQS-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic             can_accept;
  logic             accept;
  logic             load_out;
  logic [BITS-1:0]  cv_bin;
  logic             cv_sign, cv_over, cv_com;
  logic [IDW-1:0]   cv_id;
  logic [BCD_W-1:0] cv_bcd;

  logic             out_valid_q;
  logic [BCD_W-1:0] out_bcd_q;
  logic [IDW-1:0]   out_id_q;

  rr_arbiter #(.REQS(REQS), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (req_valid),
    .en_i    (can_accept),
    .grant_o (grant),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign req_ready = grant;
  assign accept    = win_found && can_accept;

`ifdef BCD_CONV_PIPE_EN
  logic            s1_valid_q;
  logic [BITS-1:0] s1_bin_q;
  logic            s1_sign_q, s1_over_q, s1_com_q;
  logic [IDW-1:0]  s1_id_q;
  logic            s1_adv;

  assign s1_adv     = !out_valid_q || out_ready;
  assign can_accept = !rst && (!s1_valid_q || s1_adv);
  assign load_out   = s1_valid_q && s1_adv;

  // Stage-1 capture of the granted operand; empties when it moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_over_q  <= 1'b0;
      s1_com_q   <= 1'b0;
      s1_id_q    <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_bin_q   <= req_bin[win_idx];
      s1_sign_q  <= req_sign[win_idx];
      s1_over_q  <= req_over[win_idx];
      s1_com_q   <= req_com[win_idx];
      s1_id_q    <= win_idx;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  assign cv_bin  = s1_bin_q;
  assign cv_sign = s1_sign_q;
  assign cv_over = s1_over_q;
  assign cv_com  = s1_com_q;
  assign cv_id   = s1_id_q;
`else
  assign can_accept = !rst && (!out_valid_q || out_ready);
  assign load_out   = accept;
  assign cv_bin     = req_bin[win_idx];
  assign cv_sign    = req_sign[win_idx];
  assign cv_over    = req_over[win_idx];
  assign cv_com     = req_com[win_idx];
  assign cv_id      = win_idx;
`endif

  BIN_to_BCD #(.BITS(BITS), .DIGITS(DIGITS)) u_conv (
    .bin_i  (cv_bin),
    .sign_i (cv_sign),
    .over_i (cv_over),
    .com_i  (cv_com),
    .bcd_o  (cv_bcd)
  );

  // Output register: reload on new result, hold under backpressure, clear on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_id_q    <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_bcd_q   <= cv_bcd;
      out_id_q    <= cv_id;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus random
// traffic against an arithmetic BCD model and an in-order scoreboard.
module tb_bcd_conv_arbiter;

  localparam int unsigned BITS   = 16;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned REQS   = 4;
`ifdef BCD_CONV_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [REQS-1:0]           req_valid;
  logic [REQS-1:0]           req_ready;
  logic [REQS-1:0][BITS-1:0] req_bin;
  logic [REQS-1:0]           req_sign, req_over, req_com;
  logic                      out_valid;
  logic                      out_ready;
  logic [4*DIGITS-1:0]       out_bcd;
  logic [1:0]                out_id;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.BITS(BITS), .DIGITS(DIGITS), .REQS(REQS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bin   (req_bin),
    .req_sign  (req_sign),
    .req_over  (req_over),
    .req_com   (req_com),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_id    (out_id)
  );

  typedef struct {
    logic [23:0] bcd;
    int unsigned id;
    int unsigned acc;
  } exp_t;

  exp_t            sb[$];
  int              grant_log[$];
  int              checks = 0;
  int              errors = 0;
  int unsigned     cyc = 0;
  int unsigned     m_ptr = 0;
  bit              prev_hold = 0;
  logic [23:0]     hold_bcd;
  logic [1:0]      hold_id;
  logic [REQS-1:0] acc_mask;
  int              last_grant = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected word from plain decimal arithmetic.
  function automatic logic [23:0] ref_bcd(input int unsigned v, input bit s, input bit o, input bit c);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS - 1; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    r[23:20] = (c && o) ? 4'hB : (s ? 4'hA : 4'hC);
    return r;
  endfunction

  function automatic int ref_winner(input logic [REQS-1:0] v, input int unsigned ptr);
    for (int unsigned i = 0; i < REQS; i++) begin
      if (v[(ptr + i) % REQS]) return int'((ptr + i) % REQS);
    end
    return -1;
  endfunction

  // One clock: sample at the falling edge, check against the model, then advance.
  task automatic step();
    int unsigned     n_in;
    bit              can;
    int              w;
    logic [REQS-1:0] exp_ready;
    logic [REQS-1:0] xfer;
    exp_t            e;
    @(negedge clk);
    cyc++;
    acc_mask = '0;
    if (rst) begin
      check("rst_ready", 32'(req_ready), 32'd0);
      sb.delete();
      m_ptr     = 0;
      prev_hold = 0;
    end else begin
      n_in = sb.size();
      if (n_in > 0) check("out_valid", 32'(out_valid), 32'(cyc >= sb[0].acc + LAT));
      else          check("out_valid_idle", 32'(out_valid), 32'd0);
      if (prev_hold) begin
        check("hold_bcd", 32'(out_bcd), 32'(hold_bcd));
        check("hold_id", 32'(out_id), 32'(hold_id));
      end
`ifdef BCD_CONV_PIPE_EN
      can = (n_in <= (out_valid ? 1 : 0)) || !out_valid || out_ready;
`else
      can = !out_valid || out_ready;
`endif
      if (out_valid && out_ready && n_in > 0) begin
        e = sb.pop_front();
        check("out_bcd", 32'(out_bcd), 32'(e.bcd));
        check("out_id", 32'(out_id), e.id);
      end
      prev_hold = out_valid && !out_ready;
      hold_bcd  = out_bcd;
      hold_id   = out_id;
      w = ref_winner(req_valid, m_ptr);
      exp_ready = (w >= 0 && can) ? (REQS'(1) << w) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      if (exp_ready != '0) begin
        m_ptr      = (32'(w) + 1) % REQS;
        last_grant = w;
        grant_log.push_back(w);
      end
      xfer = req_valid & req_ready;
      for (int k = 0; k < REQS; k++) begin
        if (xfer[k] && acc_mask == '0) begin
          e.bcd = ref_bcd(32'(req_bin[k]), req_sign[k], req_over[k], req_com[k]);
          e.id  = k;
          e.acc = cyc;
          sb.push_back(e);
          acc_mask[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // New operand for requester k.
  task automatic new_val(input int k);
    req_bin[k]  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    req_sign[k] = 1'($urandom);
    req_over[k] = 1'($urandom);
    req_com[k]  = 1'($urandom);
  endtask

  // Hold pending requests; re-roll accepted or idle ones.
  task automatic refresh();
    for (int k = 0; k < REQS; k++) begin
      if (acc_mask[k] || !req_valid[k]) begin
        req_valid[k] = 1'($urandom);
        new_val(k);
      end
    end
  endtask

  task automatic single(input int k, input logic [15:0] b, input bit s, input bit o,
                        input bit c, input logic [23:0] exp);
    req_valid   = '0;
    req_valid[k] = 1'b1;
    req_bin[k]  = b;
    req_sign[k] = s;
    req_over[k] = o;
    req_com[k]  = c;
    out_ready   = 1'b1;
    step();
    req_valid = '0;
    repeat (LAT - 1) step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_bcd", 32'(out_bcd), 32'(exp));
    check("single_id", 32'(out_id), 32'(k));
    step();
    check("single_once", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n_acc;
    rst       = 1'b1;
    req_valid = '0;
    req_bin   = '0;
    req_sign  = '0;
    req_over  = '0;
    req_com   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_bcd", 32'(out_bcd), 32'd0);
    check("reset_id", 32'(out_id), 32'd0);

    // Sign/flag encodings and single-request latency.
    single(0, 16'd1234, 0, 0, 0, 24'hC01234);
    single(1, 16'd42, 1, 0, 0, 24'hA00042);
    single(2, 16'd65535, 0, 1, 1, 24'hB65535);
    single(1, 16'd7, 0, 1, 0, 24'hC00007);
    single(2, 16'd500, 1, 1, 0, 24'hA00500);
    single(3, 16'd0, 0, 0, 0, 24'hC00000);

    // All requesters continuously valid: strict rotation at full rate.
    grant_log.delete();
    req_valid = '1;
    for (int k = 0; k < REQS; k++) new_val(k);
    repeat (12) begin
      step();
      for (int k = 0; k < REQS; k++) if (acc_mask[k]) new_val(k);
    end
    check("rr_count", 32'(grant_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++)
      check("rr_order", 32'(grant_log[i]), 32'(i % REQS));
    req_valid = '0;
    repeat (4) step();

    // Backpressure with requester 2 continuously valid.
    req_valid    = '0;
    req_valid[2] = 1'b1;
    new_val(2);
    out_ready = 1'b0;
    n_acc = 0;
    repeat (5) begin
      step();
      if (acc_mask[2]) begin
        n_acc++;
        new_val(2);
      end
    end
    check("bp_accepts", 32'(n_acc), 32'(LAT));
    check("bp_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    out_ready = 1'b1;
    repeat (LAT + 2) step();
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Random traffic.
    repeat (400) begin
      out_ready = ($urandom_range(0, 3) != 0);
      refresh();
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (LAT + 2) step();

    // Reset while a result is held.
    req_valid    = 4'b0001;
    new_val(0);
    out_ready = 1'b0;
    repeat (LAT + 1) step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    req_valid = 4'b1010;
    new_val(1);
    new_val(3);
    out_ready = 1'b1;
    step();
    check("post_rst_grant", 32'(last_grant), 32'd1);
    req_valid = '0;
    repeat (LAT + 3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
